if_stage: RTL
=============

Name: if_stage

Overview:
- Instruction-fetch stage of the MUSA core.
- Sits at the other end of the next-address path that the execute stage produces: it consumes next_address and redirect from execute and supplies the decode stage with the {pc, instruction} stream.
- Owns the PC register and a single-outstanding-request handshake to instruction memory.
- Buffers fetched words in a small FIFO so that decode stalls do not drop responses.

Parameters:
- RESET_PC, 32'h0000_0000, PC loaded on reset.
- FIFO_DEPTH, 2, instruction buffer entries (power of 2, >= 2).
- PC_STEP, 4, byte increment between sequential fetches.

Ports:
- clk  input  1  core clock; all state updates on rising edge.
- reset  input  1  synchronous, active-high reset.
- next_address  input  32  redirect target from execute stage.
- redirect  input  1  branch taken or jump from execute stage; load next_address.
- imem_req  output  1  fetch request valid.
- imem_addr  output  32  fetch address, equal to current pc.
- imem_ready  input  1  memory accepts request; handshake completes when imem_req & imem_ready.
- imem_valid  input  1  response valid; arrives one or more cycles after acceptance.
- imem_rdata  input  32  instruction word.
- instr_valid  output  1  FIFO head valid toward decode.
- instr_out  output  32  FIFO head instruction.
- pc_out  output  32  FIFO head pc.
- instr_ready  input  1  decode consumes head; pop on instr_valid & instr_ready.

Behaviour:
- Reset (synchronous, has priority over everything):
  - pc=RESET_PC; FIFO empty; outstanding=0; discard=0.
  - imem_req=0, instr_valid=0, instr_out=0, pc_out=0.
- FSM with three states:
  - IDLE: no request outstanding.
  - WAIT: request accepted, response pending.
  - DISCARD: pending response belongs to a flushed path.
- Issue rule, evaluated in IDLE: imem_req=1 when (fifo_count + 1) <= FIFO_DEPTH and redirect=0. A full FIFO holds the request off, so a response always has room.
- IDLE -> WAIT on acceptance (imem_req & imem_ready):
  - req_pc <= pc; pc <= pc + PC_STEP, wrapping modulo 2^32.
  - imem_addr must stay stable while imem_req=1 and imem_ready=0.
- WAIT, imem_valid=1:
  - push {req_pc, imem_rdata} into the FIFO; -> IDLE.
  - A new request may assert from the next cycle, giving throughput of one instruction per two cycles with 1-cycle memory.
- WAIT, redirect=1 without imem_valid: -> DISCARD.
- WAIT, redirect=1 and imem_valid=1 in the same cycle: response dropped, no push; -> IDLE.
- DISCARD, imem_valid=1: drop the response; -> IDLE.
- DISCARD, further redirect: stay in DISCARD; the latest next_address wins.
- Redirect, any state:
  - pc <= next_address; FIFO flushed, count=0; instr_valid=0 next cycle.
  - Any push or pop in that cycle is cancelled.
  - The first request to the new target issues no earlier than the following cycle.
- FIFO:
  - Circular buffer with read/write pointers and a count; simultaneous push and pop allowed at any occupancy.
  - Outputs come straight from the head register (registered, no combinational path from imem_rdata).
  - Push latency: response cycle N -> instr_valid=1 at cycle N+1.
  - Pop while empty is ignored; a push is never presented when full, by the issue rule.
- imem_valid in IDLE is a protocol error: ignored, no push.
- Reset mid-transaction: the in-flight response after reset is ignored because the FSM is IDLE.

Decomposition:
- Shared core package holds:
  - XLEN=32 and the RESET_PC default.
  - Fetch FSM state encoding: IDLE=2'd0, WAIT=2'd1, DISCARD=2'd2.
  - FIFO entry type {pc[31:0], instr[31:0]}.
- One sub-module: if_fifo, a parameterised synchronous FIFO with push, pop, flush, full, empty and count, reset synchronous active-high.

Test Plan:
- Reset and sequential fetch: release reset, 1-cycle memory, instr_ready=1 -> imem_addr 0,4,8,12; decode sees pc_out 0,4,8 with matching words, in order, none lost.
- Backpressure: instr_ready=0 for 10 cycles -> exactly FIFO_DEPTH=2 entries buffered, imem_req then stays 0; on release, entries pop in order and fetch resumes at pc 8.
- Redirect while in WAIT: request to 0x10 outstanding, redirect with next_address=0x100, response arrives 3 cycles later -> response dropped, next imem_addr=0x100, first pc_out=0x100.
- Simultaneous redirect and response: imem_valid=1 in the same cycle as redirect to 0x40 -> no push, FIFO empty, next request to 0x40.
- Memory wait states: imem_ready=0 for 4 cycles -> imem_addr held constant at 0x0, exactly one acceptance recorded.
- Mid-operation reset and wrap-around:
  - Reset asserted in WAIT -> all outputs 0 next cycle, stale response ignored, fetch restarts at RESET_PC.
  - Redirect to 0xFFFFFFFC -> next sequential fetch to 0x00000000.

Source files
------------

// File: rtl/if_stage_pkg.sv
// Shared definitions for the MUSA instruction-fetch stage.
// Contents:
//   XLEN             - datapath width
//   RESET_PC_DEFAULT - default PC loaded on reset
//   fetch_state_e    - fetch FSM state encoding
//   fetch_entry_t    - instruction buffer entry {pc, instr}
package if_stage_pkg;

  localparam int unsigned XLEN = 32;
  localparam logic [XLEN-1:0] RESET_PC_DEFAULT = 32'h0000_0000;

  typedef enum logic [1:0] {
    StIdle    = 2'd0,  // no request outstanding
    StWait    = 2'd1,  // request accepted, response pending
    StDiscard = 2'd2   // pending response belongs to a flushed path
  } fetch_state_e;

  typedef struct packed {
    logic [XLEN-1:0] pc;
    logic [XLEN-1:0] instr;
  } fetch_entry_t;

endpackage

// File: rtl/if_stage_if.sv
// Bus bundle of the fetch stage: instruction-memory handshake plus the
// {pc, instruction} stream toward decode.
// Modports:
//   master - the fetch stage (drives imem_req/imem_addr and the decode stream)
//   slave  - the environment (memory and decode)
interface if_stage_if;
  import if_stage_pkg::*;

  // Instruction memory
  logic            imem_req;
  logic [XLEN-1:0] imem_addr;
  logic            imem_ready;
  logic            imem_valid;
  logic [XLEN-1:0] imem_rdata;

  // Decode stream
  logic            instr_valid;
  logic [XLEN-1:0] instr_out;
  logic [XLEN-1:0] pc_out;
  logic            instr_ready;

  modport master (
    output imem_req, imem_addr,
    input  imem_ready, imem_valid, imem_rdata,
    output instr_valid, instr_out, pc_out,
    input  instr_ready
  );

  modport slave (
    input  imem_req, imem_addr,
    output imem_ready, imem_valid, imem_rdata,
    input  instr_valid, instr_out, pc_out,
    output instr_ready
  );

endinterface

// File: rtl/if_fifo.sv
// Synchronous circular-buffer FIFO holding fetched {pc, instr} entries.
// Ports:
//   clk, reset - clock and synchronous active-high reset
//   push_i     - write wdata_i at the tail (accepted when not full or popping)
//   pop_i      - drop the head entry (ignored when empty)
//   flush_i    - empty the buffer; cancels any push/pop in the same cycle
//   rdata_o    - head entry, driven from storage registers
//   full_o, empty_o, count_o - occupancy status
module if_fifo
  import if_stage_pkg::*;
#(
  parameter int unsigned Depth = 2  // power of two, >= 2
) (
  input  logic                           clk,
  input  logic                           reset,
  input  logic                           push_i,
  input  fetch_entry_t                   wdata_i,
  input  logic                           pop_i,
  input  logic                           flush_i,
  output fetch_entry_t                   rdata_o,
  output logic                           full_o,
  output logic                           empty_o,
  output logic [$clog2(Depth+1)-1:0]     count_o
);

  localparam int unsigned PtrW = $clog2(Depth);
  localparam int unsigned CntW = $clog2(Depth + 1);

  fetch_entry_t    mem_q [Depth];
  logic [PtrW-1:0] wr_ptr_q, rd_ptr_q;
  logic [CntW-1:0] count_q;
  logic            push_en, pop_en;

  assign full_o  = (count_q == CntW'(Depth));
  assign empty_o = (count_q == '0);
  assign count_o = count_q;
  assign rdata_o = mem_q[rd_ptr_q];

  assign pop_en  = pop_i & ~empty_o;
  // A pop in the same cycle frees the slot, so push is legal even when full.
  assign push_en = push_i & (~full_o | pop_en);

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      for (int unsigned i = 0; i < Depth; i++) begin
        mem_q[i] <= '0;
      end
    end else if (flush_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (push_en) begin
        mem_q[wr_ptr_q] <= wdata_i;
        wr_ptr_q        <= wr_ptr_q + PtrW'(1);
      end
      if (pop_en) begin
        rd_ptr_q <= rd_ptr_q + PtrW'(1);
      end
      case ({push_en, pop_en})
        2'b10:   count_q <= count_q + CntW'(1);
        2'b01:   count_q <= count_q - CntW'(1);
        default: count_q <= count_q;
      endcase
    end
  end

endmodule

// File: rtl/if_stage.sv
// MUSA instruction-fetch stage.
// Owns the PC, issues one outstanding request at a time to instruction memory
// and buffers responses in a small FIFO toward decode.
// Ports:
//   clk, reset   - core clock, synchronous active-high reset
//   next_address - redirect target from execute
//   redirect     - load next_address, flush buffered and in-flight fetches
//   bus          - if_stage_if.master: imem handshake and decode stream
module if_stage
  import if_stage_pkg::*;
#(
  parameter logic [XLEN-1:0] RESET_PC   = RESET_PC_DEFAULT,
  parameter int unsigned     FIFO_DEPTH = 2,
  parameter logic [XLEN-1:0] PC_STEP    = 32'd4
) (
  input  logic            clk,
  input  logic            reset,
  input  logic [XLEN-1:0] next_address,
  input  logic            redirect,
  if_stage_if.master      bus
);

  localparam int unsigned     CntW     = $clog2(FIFO_DEPTH + 1);
  localparam logic [CntW-1:0] DepthCnt = CntW'(FIFO_DEPTH);

  fetch_state_e    state_q;
  logic [XLEN-1:0] pc_q;
  logic [XLEN-1:0] req_pc_q;

  logic            accept;
  logic            fifo_push, fifo_pop;
  logic            fifo_full, fifo_empty;
  logic [CntW-1:0] fifo_count;
  fetch_entry_t    fifo_wdata, fifo_head;

  // Only issue when the response is guaranteed a FIFO slot; a redirect this
  // cycle holds the request so the first fetch to the new target goes next cycle.
  assign bus.imem_req  = (state_q == StIdle) & (fifo_count < DepthCnt) & ~redirect & ~reset;
  assign bus.imem_addr = pc_q;
  assign accept        = bus.imem_req & bus.imem_ready;

  // Responses in StDiscard and responses coinciding with a redirect are dropped.
  assign fifo_push = (state_q == StWait) & bus.imem_valid & ~redirect;
  assign fifo_pop  = bus.instr_valid & bus.instr_ready;

  assign fifo_wdata = '{pc: req_pc_q, instr: bus.imem_rdata};

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= StIdle;
      pc_q     <= RESET_PC;
      req_pc_q <= '0;
    end else if (redirect) begin
      pc_q <= next_address;
      // An outstanding response must still be absorbed unless it is here now.
      if (state_q != StIdle) begin
        state_q <= bus.imem_valid ? StIdle : StDiscard;
      end
    end else begin
      case (state_q)
        StIdle: begin
          if (accept) begin
            req_pc_q <= pc_q;
            pc_q     <= pc_q + PC_STEP;
            state_q  <= StWait;
          end
        end
        StWait, StDiscard: begin
          if (bus.imem_valid) begin
            state_q <= StIdle;
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  if_fifo #(
    .Depth (FIFO_DEPTH)
  ) u_fifo (
    .clk     (clk),
    .reset   (reset),
    .push_i  (fifo_push),
    .wdata_i (fifo_wdata),
    .pop_i   (fifo_pop),
    .flush_i (redirect),
    .rdata_o (fifo_head),
    .full_o  (fifo_full),
    .empty_o (fifo_empty),
    .count_o (fifo_count)
  );

  assign bus.instr_valid = ~fifo_empty;
  assign bus.instr_out   = fifo_head.instr;
  assign bus.pc_out      = fifo_head.pc;

  // The issue rule reserves a slot for every response.
  push_never_overflows: assert property (
    @(posedge clk) disable iff (reset) !(fifo_push && fifo_full && !fifo_pop)
  );

endmodule
